// File: rtl/alu_div_seq_pkg.sv
// Shared definitions for the sequential divide/remainder unit.
//   XLEN        : datapath width of the integer core
//   ALUOP_SUB   : opcode that makes the shared alu produce a - b
//   div_state_e : sequencer states (3-bit encoding)
package alu_div_seq_pkg;

  localparam int XLEN = 64;

  localparam logic [3:0] ALUOP_SUB = 4'd1;

  typedef enum logic [2:0] {
    DIVST_IDLE  = 3'd0,
    DIVST_ABS_A = 3'd1,
    DIVST_ABS_B = 3'd2,
    DIVST_DIV   = 3'd3,
    DIVST_FIX   = 3'd4,
    DIVST_DONE  = 3'd5
  } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign handling around the divide loop.
// Accept-side ports (acc_*): request operands and flags as presented on the
//   request interface; produce special-case detection/result and operand signs.
// Fix-side ports: latched signs, result kind and loop results; produce the
//   selected magnitude and whether it must be negated.
module div_sign_fix
  import alu_div_seq_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic         acc_signed_i,
  input  logic         acc_rem_i,
  input  logic [W-1:0] acc_a_i,
  input  logic [W-1:0] acc_b_i,
  output logic         special_o,
  output logic [W-1:0] special_res_o,
  output logic         acc_sign_a_o,
  output logic         acc_sign_b_o,
  input  logic         sign_a_i,
  input  logic         sign_b_i,
  input  logic         rem_sel_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] rem_i,
  output logic [W-1:0] sel_o,
  output logic         neg_res_o
);

  localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] ZERO     = {W{1'b0}};

  logic div_zero_s;
  logic overflow_s;

  // Detect divide-by-zero and signed overflow; these bypass the loop entirely.
  always_comb begin
    div_zero_s = (acc_b_i == ZERO);
    overflow_s = acc_signed_i & (acc_a_i == MIN_NEG) & (acc_b_i == ALL_ONES);
    special_o  = div_zero_s | overflow_s;
    if (div_zero_s) begin
      if (acc_rem_i) begin
        special_res_o = acc_a_i;
      end else begin
        special_res_o = ALL_ONES;
      end
    end else if (overflow_s) begin
      if (acc_rem_i) begin
        special_res_o = ZERO;
      end else begin
        special_res_o = acc_a_i;
      end
    end else begin
      special_res_o = ZERO;
    end
  end

  // Operand signs only matter for signed requests; result sign follows
  // the dividend for remainders and the XOR of both signs for quotients.
  always_comb begin
    acc_sign_a_o = acc_signed_i & acc_a_i[W-1];
    acc_sign_b_o = acc_signed_i & acc_b_i[W-1];
    if (rem_sel_i) begin
      sel_o     = rem_i;
      neg_res_o = sign_a_i;
    end else begin
      sel_o     = quo_i;
      neg_res_o = sign_a_i ^ sign_b_i;
    end
  end

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer (radix-2 restoring division).
// Borrows the shared alu adder while alu_busy_o is high.
// Ports:
//   clk, rst_n (async active-low), flush_i (sync abort)
//   div_valid_i/div_ready_o, div_signed_i, div_rem_i, div_a_i, div_b_i : request
//   res_valid_o/res_ready_i, res_o                                       : result
//   alu_busy_o, alu_a_o, alu_b_o, alu_op_o                               : alu drive
//   alu_out_i, alu_slt_i                                                 : alu return
module alu_div_seq
  import alu_div_seq_pkg::*;
#(
  parameter int W     = XLEN,
  parameter int CNT_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         div_valid_i,
  output logic         div_ready_o,
  input  logic         div_signed_i,
  input  logic         div_rem_i,
  input  logic [W-1:0] div_a_i,
  input  logic [W-1:0] div_b_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [W-1:0] res_o,
  output logic         alu_busy_o,
  output logic [W-1:0] alu_a_o,
  output logic [W-1:0] alu_b_o,
  output logic [3:0]   alu_op_o,
  input  logic [W-1:0] alu_out_i,
  input  logic         alu_slt_i
);

  localparam logic [W-1:0]     MSB_MASK = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]     ZERO     = {W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W-1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  div_state_e       state_r, state_nxt_s;
  logic [W-1:0]     opa_r, opa_nxt_s;      // dividend, then its magnitude
  logic [W-1:0]     opb_r, opb_nxt_s;      // divisor, then its magnitude
  logic [W-1:0]     rem_r, rem_nxt_s;      // partial remainder R
  logic [W-1:0]     quo_r, quo_nxt_s;      // dividend shifting out / quotient Q
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             rem_sel_r, rem_sel_nxt_s;
  logic             sign_a_r, sign_a_nxt_s;
  logic             sign_b_r, sign_b_nxt_s;
  logic [W-1:0]     res_r, res_nxt_s;
  logic             res_valid_r, res_valid_nxt_s;
  logic             ready_r, ready_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic [W-1:0]     alu_a_r, alu_a_nxt_s;
  logic [W-1:0]     alu_b_r, alu_b_nxt_s;
  logic [3:0]       alu_op_r, alu_op_nxt_s;

  logic [W-1:0]     r_shift_s;
  logic             sub_s;
  logic             special_s;
  logic [W-1:0]     special_res_s;
  logic             acc_sign_a_s;
  logic             acc_sign_b_s;
  logic [W-1:0]     sel_s;
  logic             neg_res_s;

  div_sign_fix #(.W(W)) u_sign_fix (
    .acc_signed_i  (div_signed_i),
    .acc_rem_i     (div_rem_i),
    .acc_a_i       (div_a_i),
    .acc_b_i       (div_b_i),
    .special_o     (special_s),
    .special_res_o (special_res_s),
    .acc_sign_a_o  (acc_sign_a_s),
    .acc_sign_b_o  (acc_sign_b_s),
    .sign_a_i      (sign_a_r),
    .sign_b_i      (sign_b_r),
    .rem_sel_i     (rem_sel_r),
    .quo_i         (quo_r),
    .rem_i         (rem_r),
    .sel_o         (sel_s),
    .neg_res_o     (neg_res_s)
  );

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    opa_nxt_s       = opa_r;
    opb_nxt_s       = opb_r;
    rem_nxt_s       = rem_r;
    quo_nxt_s       = quo_r;
    cnt_nxt_s       = cnt_r;
    rem_sel_nxt_s   = rem_sel_r;
    sign_a_nxt_s    = sign_a_r;
    sign_b_nxt_s    = sign_b_r;
    res_nxt_s       = res_r;
    res_valid_nxt_s = res_valid_r;
    r_shift_s       = {rem_r[W-2:0], quo_r[W-1]};
    // A bit shifted out of R means R_shift >= 2^W > D, so subtract regardless.
    sub_s           = rem_r[W-1] | ~alu_slt_i;
    if (flush_i) begin
      state_nxt_s     = DIVST_IDLE;
      res_valid_nxt_s = 1'b0;
    end else begin
      case (state_r)
        DIVST_IDLE: begin
          if (div_valid_i) begin
            opa_nxt_s     = div_a_i;
            opb_nxt_s     = div_b_i;
            rem_sel_nxt_s = div_rem_i;
            sign_a_nxt_s  = acc_sign_a_s;
            sign_b_nxt_s  = acc_sign_b_s;
            if (special_s) begin
              res_nxt_s       = special_res_s;
              res_valid_nxt_s = 1'b1;
              state_nxt_s     = DIVST_DONE;
            end else begin
              state_nxt_s = DIVST_ABS_A;
            end
          end else begin
            state_nxt_s = DIVST_IDLE;
          end
        end
        DIVST_ABS_A: begin
          if (sign_a_r) begin
            opa_nxt_s = alu_out_i;
          end else begin
            opa_nxt_s = opa_r;
          end
          state_nxt_s = DIVST_ABS_B;
        end
        DIVST_ABS_B: begin
          if (sign_b_r) begin
            opb_nxt_s = alu_out_i;
          end else begin
            opb_nxt_s = opb_r;
          end
          rem_nxt_s   = ZERO;
          quo_nxt_s   = opa_r;
          cnt_nxt_s   = CNT_LAST;
          state_nxt_s = DIVST_DIV;
        end
        DIVST_DIV: begin
          if (sub_s) begin
            rem_nxt_s = alu_out_i;
          end else begin
            rem_nxt_s = r_shift_s;
          end
          quo_nxt_s = {quo_r[W-2:0], sub_s};
          if (cnt_r == CNT_ZERO) begin
            state_nxt_s = DIVST_FIX;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
        end
        DIVST_FIX: begin
          if (neg_res_s) begin
            res_nxt_s = alu_out_i;
          end else begin
            res_nxt_s = sel_s;
          end
          res_valid_nxt_s = 1'b1;
          state_nxt_s     = DIVST_DONE;
        end
        DIVST_DONE: begin
          if (res_ready_i) begin
            res_valid_nxt_s = 1'b0;
            state_nxt_s     = DIVST_IDLE;
          end else begin
            state_nxt_s = DIVST_DONE;
          end
        end
        default: begin
          res_valid_nxt_s = 1'b0;
          state_nxt_s     = DIVST_IDLE;
        end
      endcase
    end
  end

  // ALU drive for the coming cycle, derived from the next state so the
  // registered outputs already carry the right operands in that state.
  always_comb begin
    busy_nxt_s  = 1'b0;
    alu_a_nxt_s = ZERO;
    alu_b_nxt_s = ZERO;
    case (state_nxt_s)
      DIVST_ABS_A: begin
        busy_nxt_s  = 1'b1;
        alu_b_nxt_s = opa_nxt_s;
      end
      DIVST_ABS_B: begin
        busy_nxt_s  = 1'b1;
        alu_b_nxt_s = opb_nxt_s;
      end
      DIVST_DIV: begin
        // MSB flip on both operands turns the signed slt into unsigned compare.
        busy_nxt_s  = 1'b1;
        alu_a_nxt_s = {rem_nxt_s[W-2:0], quo_nxt_s[W-1]} ^ MSB_MASK;
        alu_b_nxt_s = opb_nxt_s ^ MSB_MASK;
      end
      DIVST_FIX: begin
        busy_nxt_s = 1'b1;
        if (rem_sel_nxt_s) begin
          alu_b_nxt_s = rem_nxt_s;
        end else begin
          alu_b_nxt_s = quo_nxt_s;
        end
      end
      default: begin
        busy_nxt_s  = 1'b0;
        alu_a_nxt_s = ZERO;
        alu_b_nxt_s = ZERO;
      end
    endcase
    if (busy_nxt_s) begin
      alu_op_nxt_s = ALUOP_SUB;
    end else begin
      alu_op_nxt_s = 4'd0;
    end
    ready_nxt_s = (state_nxt_s == DIVST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= DIVST_IDLE;
      opa_r       <= ZERO;
      opb_r       <= ZERO;
      rem_r       <= ZERO;
      quo_r       <= ZERO;
      cnt_r       <= CNT_ZERO;
      rem_sel_r   <= 1'b0;
      sign_a_r    <= 1'b0;
      sign_b_r    <= 1'b0;
      res_r       <= ZERO;
      res_valid_r <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      alu_a_r     <= ZERO;
      alu_b_r     <= ZERO;
      alu_op_r    <= 4'd0;
    end else begin
      state_r     <= state_nxt_s;
      opa_r       <= opa_nxt_s;
      opb_r       <= opb_nxt_s;
      rem_r       <= rem_nxt_s;
      quo_r       <= quo_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rem_sel_r   <= rem_sel_nxt_s;
      sign_a_r    <= sign_a_nxt_s;
      sign_b_r    <= sign_b_nxt_s;
      res_r       <= res_nxt_s;
      res_valid_r <= res_valid_nxt_s;
      ready_r     <= ready_nxt_s;
      busy_r      <= busy_nxt_s;
      alu_a_r     <= alu_a_nxt_s;
      alu_b_r     <= alu_b_nxt_s;
      alu_op_r    <= alu_op_nxt_s;
    end
  end

  assign div_ready_o = ready_r;
  assign res_valid_o = res_valid_r;
  assign res_o       = res_r;
  assign alu_busy_o  = busy_r;
  assign alu_a_o     = alu_a_r;
  assign alu_b_o     = alu_b_r;
  assign alu_op_o    = alu_op_r;

endmodule
